// File: rtl/pw_tile_scheduler_pkg.sv
// rtl/pw_tile_scheduler_pkg.sv - shared widths, defaults and state encoding for the PW tile scheduler
package pw_sched_pkg;

  localparam int PIX_W           = 8;
  localparam int K_W             = 7;
  localparam int CH_W            = 8;
  localparam int MACK_W          = 6;
  localparam int ACT_W           = 8;
  localparam int PIXEL_TILE_SIZE = 128;
  localparam int K_MAX           = 64;

  typedef enum logic [3:0] {
    S_IDLE, S_WLOAD, S_WWAIT, S_COMMIT, S_PIX, S_PSWAIT, S_STEP,
    S_DRAIN, S_SPILL, S_QUANT, S_QWAIT, S_OUT, S_NEXT
  } state_e;

endpackage

// File: rtl/pw_tile_scheduler_if.sv
// rtl/pw_tile_scheduler_if.sv - scheduler-to-datapath signal bundle
// master is the scheduler side; slave is the weight/psum/MAC/requant environment.
interface pw_tile_scheduler_if;
  import pw_sched_pkg::*;

  logic               start;
  logic [PIX_W-1:0]   cfg_num_pix;
  logic [CH_W-1:0]    cfg_num_chunks;
  logic [K_W-1:0]     cfg_k_len;
  logic               busy;
  logic               done;
  logic               wt_load_start;
  logic               wt_load_done;
  logic               wt_bank_commit;
  logic               psum_do_read;
  logic               psum_rd_valid;
  logic               psum_do_write;
  logic [PIX_W-1:0]   t_in_tile;
  logic               mac_clear_pulse;
  logic               mac_load_pulse;
  logic               mac_step_en;
  logic [MACK_W-1:0]  mac_k;
  logic [ACT_W-1:0]   mac_act_k;
  logic               act_req;
  logic [PIX_W-1:0]   act_pix;
  logic [MACK_W-1:0]  act_kidx;
  logic               act_valid;
  logic [ACT_W-1:0]   act_data;
  logic               q_en;
  logic               q_valid;
  logic               out_valid;
  logic               out_ready;
  logic [PIX_W-1:0]   out_pix;

  modport master (
    input  start, cfg_num_pix, cfg_num_chunks, cfg_k_len, wt_load_done, psum_rd_valid,
           act_valid, act_data, q_valid, out_ready,
    output busy, done, wt_load_start, wt_bank_commit, psum_do_read, psum_do_write, t_in_tile,
           mac_clear_pulse, mac_load_pulse, mac_step_en, mac_k, mac_act_k, act_req, act_pix,
           act_kidx, q_en, out_valid, out_pix
  );

  modport slave (
    output start, cfg_num_pix, cfg_num_chunks, cfg_k_len, wt_load_done, psum_rd_valid,
           act_valid, act_data, q_valid, out_ready,
    input  busy, done, wt_load_start, wt_bank_commit, psum_do_read, psum_do_write, t_in_tile,
           mac_clear_pulse, mac_load_pulse, mac_step_en, mac_k, mac_act_k, act_req, act_pix,
           act_kidx, q_en, out_valid, out_pix
  );

endinterface

// File: rtl/pw_tile_scheduler_loop_ctr.sv
// rtl/pw_tile_scheduler_loop_ctr.sv - nested chunk/pixel/k counters with latched, clamped tile config
module pw_loop_ctr
  import pw_sched_pkg::*;
#(
  parameter int PIX_MAX = PIXEL_TILE_SIZE,
  parameter int KMAX    = K_MAX
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              load,
  input  logic [PIX_W-1:0]  cfg_num_pix,
  input  logic [CH_W-1:0]   cfg_num_chunks,
  input  logic [K_W-1:0]    cfg_k_len,
  input  logic              pix_clr,
  input  logic              pix_inc,
  input  logic              k_clr,
  input  logic              k_inc,
  input  logic              chunk_clr,
  input  logic              chunk_inc,
  output logic [PIX_W-1:0]  pix,
  output logic [MACK_W-1:0] k_idx,
  output logic              cfg_zero,
  output logic              k_last,
  output logic              pix_last,
  output logic              chunk_first,
  output logic              chunk_last
);

  logic [PIX_W-1:0] num_pix_q, num_pix_d;
  logic [CH_W-1:0]  num_chunks_q, num_chunks_d;
  logic [K_W-1:0]   k_len_q, k_len_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CH_W-1:0]  chunk_q, chunk_d;

  always_comb begin
    num_pix_d    = num_pix_q;
    num_chunks_d = num_chunks_q;
    k_len_d      = k_len_q;
    if (load) begin
      num_pix_d    = (cfg_num_pix > PIX_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : cfg_num_pix;
      num_chunks_d = cfg_num_chunks;
      k_len_d      = (cfg_k_len > K_W'(KMAX)) ? K_W'(KMAX) : cfg_k_len;
    end
    pix_d = pix_q;
    if (pix_clr)      pix_d = '0;
    else if (pix_inc) pix_d = pix_q + PIX_W'(1);
    k_d = k_q;
    if (k_clr)      k_d = '0;
    else if (k_inc) k_d = k_q + K_W'(1);
    chunk_d = chunk_q;
    if (chunk_clr)      chunk_d = '0;
    else if (chunk_inc) chunk_d = chunk_q + CH_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      num_pix_q    <= '0;
      num_chunks_q <= '0;
      k_len_q      <= '0;
      pix_q        <= '0;
      k_q          <= '0;
      chunk_q      <= '0;
    end else begin
      num_pix_q    <= num_pix_d;
      num_chunks_q <= num_chunks_d;
      k_len_q      <= k_len_d;
      pix_q        <= pix_d;
      k_q          <= k_d;
      chunk_q      <= chunk_d;
    end
  end

  // k runs to KMAX after the final step, so only its low bits address weight rows
  assign pix         = pix_q;
  assign k_idx       = k_q[MACK_W-1:0];
  assign cfg_zero    = (cfg_num_pix == '0) || (cfg_num_chunks == '0) || (cfg_k_len == '0);
  assign k_last      = (k_q == k_len_q - K_W'(1));
  assign pix_last    = (pix_q + PIX_W'(1) == num_pix_q);
  assign chunk_first = (chunk_q == '0);
  assign chunk_last  = (chunk_q + CH_W'(1) == num_chunks_q);

endmodule

// File: rtl/pw_tile_scheduler.sv
// rtl/pw_tile_scheduler.sv - weight-stationary tile sequencer for the 32-lane PW core
// Pulse/level outputs are registered from the next state; step and load follow their input handshakes.
module pw_tile_scheduler
  import pw_sched_pkg::*;
#(
  parameter int PIX_TILE = PIXEL_TILE_SIZE,
  parameter int K_STEPS  = K_MAX
) (
  input  logic                CLK,
  input  logic                RESET,
  pw_tile_scheduler_if.master bus
);

  state_e state_q, state_d;
  logic busy_q, busy_d, done_q, done_d, wls_q, wls_d, commit_q, commit_d;
  logic rd_q, rd_d, wr_q, wr_d, clear_q, clear_d, req_q, req_d, qen_q, qen_d, ov_q, ov_d;
  logic load, pix_clr, pix_inc, k_clr, k_inc, chunk_clr, chunk_inc;
  logic cfg_zero, k_last, pix_last, chunk_first, chunk_last, step;
  logic [PIX_W-1:0]  pix;
  logic [MACK_W-1:0] k_idx;

  pw_loop_ctr #(.PIX_MAX(PIX_TILE), .KMAX(K_STEPS)) u_ctr (
    .CLK(CLK), .RESET(RESET), .load(load),
    .cfg_num_pix(bus.cfg_num_pix), .cfg_num_chunks(bus.cfg_num_chunks), .cfg_k_len(bus.cfg_k_len),
    .pix_clr(pix_clr), .pix_inc(pix_inc), .k_clr(k_clr), .k_inc(k_inc),
    .chunk_clr(chunk_clr), .chunk_inc(chunk_inc), .pix(pix), .k_idx(k_idx),
    .cfg_zero(cfg_zero), .k_last(k_last), .pix_last(pix_last),
    .chunk_first(chunk_first), .chunk_last(chunk_last)
  );

  assign step = (state_q == S_STEP) && bus.act_valid;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    pix_clr   = 1'b0;
    pix_inc   = 1'b0;
    k_clr     = 1'b0;
    k_inc     = 1'b0;
    chunk_clr = 1'b0;
    chunk_inc = 1'b0;
    case (state_q)
      S_IDLE: if (bus.start) begin
        load = 1'b1;
        if (!cfg_zero) begin
          state_d   = S_WLOAD;
          pix_clr   = 1'b1;
          k_clr     = 1'b1;
          chunk_clr = 1'b1;
        end
      end
      S_WLOAD:  state_d = S_WWAIT;
      S_WWAIT:  if (bus.wt_load_done) state_d = S_COMMIT;
      S_COMMIT: begin
        pix_clr = 1'b1;
        state_d = S_PIX;
      end
      S_PIX:    state_d = chunk_first ? S_STEP : S_PSWAIT;
      S_PSWAIT: if (bus.psum_rd_valid) state_d = S_STEP;
      S_STEP: if (step) begin
        k_inc = 1'b1;
        if (k_last) state_d = S_DRAIN;
      end
      S_DRAIN:  state_d = chunk_last ? S_QUANT : S_SPILL;
      S_SPILL:  state_d = S_NEXT;
      S_QUANT:  state_d = S_QWAIT;
      S_QWAIT:  if (bus.q_valid) state_d = S_OUT;
      S_OUT:    if (bus.out_ready) state_d = S_NEXT;
      S_NEXT: begin
        pix_inc = 1'b1;
        k_clr   = 1'b1;
        if (!pix_last) begin
          state_d = S_PIX;
        end else if (!chunk_last) begin
          chunk_inc = 1'b1;
          state_d   = S_WLOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d   = (state_d != S_IDLE);
    done_d   = ((state_q == S_IDLE) && bus.start && cfg_zero) ||
               ((state_q == S_NEXT) && (state_d == S_IDLE));
    wls_d    = (state_d == S_WLOAD);
    commit_d = (state_d == S_COMMIT);
    clear_d  = (state_d == S_PIX) && chunk_first;
    rd_d     = (state_d == S_PIX) && !chunk_first;
    wr_d     = (state_d == S_SPILL);
    req_d    = (state_d == S_STEP);
    qen_d    = (state_d == S_QUANT);
    ov_d     = (state_d == S_OUT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wls_q    <= 1'b0;
      commit_q <= 1'b0;
      clear_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      req_q    <= 1'b0;
      qen_q    <= 1'b0;
      ov_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wls_q    <= wls_d;
      commit_q <= commit_d;
      clear_q  <= clear_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      req_q    <= req_d;
      qen_q    <= qen_d;
      ov_q     <= ov_d;
    end
  end

  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
  assign bus.wt_load_start   = wls_q;
  assign bus.wt_bank_commit  = commit_q;
  assign bus.psum_do_read    = rd_q;
  assign bus.psum_do_write   = wr_q;
  assign bus.t_in_tile       = pix;
  assign bus.mac_clear_pulse = clear_q;
  assign bus.mac_load_pulse  = (state_q == S_PSWAIT) && bus.psum_rd_valid;
  assign bus.mac_step_en     = step;
  assign bus.mac_k           = k_idx;
  assign bus.mac_act_k       = step ? bus.act_data : '0;
  assign bus.act_req         = req_q;
  assign bus.act_pix         = pix;
  assign bus.act_kidx        = k_idx;
  assign bus.q_en            = qen_q;
  assign bus.out_valid       = ov_q;
  assign bus.out_pix         = pix;

endmodule

// File: tb/tb_pw_tile_scheduler.sv
// tb/tb_pw_tile_scheduler.sv - directed bench for pw_tile_scheduler with a golden MAC/psum model
module tb_pw_tile_scheduler;
  import pw_sched_pkg::*;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  pw_tile_scheduler_if bus();
  pw_tile_scheduler dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  int vec_cnt = 0, err_cnt = 0;
  int act_duty = 100, ready_duty = 100, psum_lat = 1, wt_lat = 2, q_lat = 1;
  int clr_gen = 0, seen_gen = 0, cur_npix = 1;
  longint golden [256];

  int cyc = 0, env_chunk = -1, rd_cnt = 0, wt_cnt = 0, q_cnt = 0, exp_out = 0;
  int n_clear, n_load, n_read, n_write, n_step, n_qen, n_wls, n_out, n_done, bad_inv, out_err, seq_err;
  int commit_cyc, done_cyc;
  bit prev_stall = 0;
  logic [7:0] prev_pix;
  longint acc = 0, q_out = 0;
  longint psum_mem [256];

  logic [55:0] all_outs;
  logic [10:0] flags;
  assign all_outs = {bus.busy, bus.done, bus.wt_load_start, bus.wt_bank_commit, bus.psum_do_read,
                     bus.psum_do_write, bus.t_in_tile, bus.mac_clear_pulse, bus.mac_load_pulse,
                     bus.mac_step_en, bus.mac_k, bus.mac_act_k, bus.act_req, bus.act_pix,
                     bus.act_kidx, bus.q_en, bus.out_valid, bus.out_pix};
  assign flags = {bus.busy, bus.wt_load_start, bus.wt_bank_commit, bus.psum_do_read, bus.psum_do_write,
                  bus.mac_clear_pulse, bus.mac_load_pulse, bus.mac_step_en, bus.act_req, bus.q_en,
                  bus.out_valid};

  function automatic int wgt(int c, int k);
    return ((c * 7 + k * 3) % 17) - 8;
  endfunction

  function automatic int actv(int p, int c, int k);
    return ((p * 5 + c * 11 + k * 13) % 251) - 125;
  endfunction

  // Environment: drives datapath responses after each rising edge, observes outputs on the falling edge
  always begin
    @(posedge CLK); #1;
    if (RESET) begin
      rd_cnt = 0; wt_cnt = 0; q_cnt = 0;
      bus.psum_rd_valid = 0; bus.wt_load_done = 0; bus.q_valid = 0;
      bus.act_valid = 0; bus.act_data = 0; bus.out_ready = 0;
    end else begin
      bus.psum_rd_valid = 0; bus.wt_load_done = 0; bus.q_valid = 0;
      if (rd_cnt > 0) begin rd_cnt--; if (rd_cnt == 0) bus.psum_rd_valid = 1; end
      if (wt_cnt > 0) begin wt_cnt--; if (wt_cnt == 0) bus.wt_load_done = 1; end
      if (q_cnt > 0)  begin q_cnt--;  if (q_cnt == 0)  bus.q_valid = 1; end
      bus.act_valid = bus.act_req && (int'($urandom_range(99)) < act_duty);
      bus.act_data  = bus.act_req ? 8'(actv(int'(bus.act_pix), env_chunk, int'(bus.act_kidx))) : 8'd0;
      bus.out_ready = (int'($urandom_range(99)) < ready_duty);
    end
    @(negedge CLK);
    cyc++;
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      n_clear = 0; n_load = 0; n_read = 0; n_write = 0; n_step = 0; n_qen = 0; n_wls = 0;
      n_out = 0; n_done = 0; bad_inv = 0; out_err = 0; seq_err = 0;
      env_chunk = -1; exp_out = 0; prev_stall = 0; commit_cyc = 0; done_cyc = 0;
    end
    if (RESET) begin
      prev_stall = 0;
    end else begin
      if (bus.mac_clear_pulse && bus.mac_load_pulse) bad_inv++;
      if (bus.mac_step_en && bus.mac_load_pulse) bad_inv++;
      if (bus.mac_load_pulse !== bus.psum_rd_valid) bad_inv++;
      if (bus.wt_bank_commit) begin env_chunk++; commit_cyc = cyc; end
      if (bus.wt_load_start) begin n_wls++; wt_cnt = wt_lat; end
      if (bus.mac_clear_pulse) begin n_clear++; acc = 0; end
      if (bus.psum_do_read) begin
        if (int'(bus.t_in_tile) != n_read % cur_npix) seq_err++;
        n_read++; rd_cnt = psum_lat;
      end
      if (bus.mac_load_pulse) begin n_load++; acc = psum_mem[bus.t_in_tile]; end
      if (bus.mac_step_en) begin
        n_step++;
        if (bus.mac_act_k !== bus.act_data || bus.mac_k !== bus.act_kidx) bad_inv++;
        acc += longint'(wgt(env_chunk, int'(bus.mac_k)) * $signed(bus.mac_act_k));
      end
      if (bus.psum_do_write) begin
        if (int'(bus.t_in_tile) != n_write % cur_npix) seq_err++;
        n_write++; psum_mem[bus.t_in_tile] = acc;
      end
      if (bus.q_en) begin n_qen++; q_out = acc; q_cnt = q_lat; end
      if (prev_stall && (!bus.out_valid || bus.out_pix !== prev_pix)) bad_inv++;
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.out_pix;
      if (bus.out_valid && bus.out_ready) begin
        if (int'(bus.out_pix) != exp_out || q_out != golden[bus.out_pix]) out_err++;
        exp_out++; n_out++;
      end
      if (bus.done) begin n_done++; done_cyc = cyc; end
    end
  end

  task automatic clear_env(input int npix, input int ch, input int kl);
    cur_npix = (npix > 128) ? 128 : npix;
    for (int p = 0; p < 256; p++) begin
      golden[p] = 0;
      if (p < cur_npix)
        for (int c = 0; c < ch; c++)
          for (int k = 0; k < kl; k++) golden[p] += longint'(wgt(c, k) * actv(p, c, k));
    end
    clr_gen++;
    @(negedge CLK); @(negedge CLK);
  endtask

  task automatic begin_tile(input int npix, input int ch, input int kl);
    @(posedge CLK); #1;
    bus.cfg_num_pix = 8'(npix); bus.cfg_num_chunks = 8'(ch); bus.cfg_k_len = 7'(kl);
    bus.start = 1;
    @(posedge CLK); #1;
    bus.start = 0;
  endtask

  task automatic wait_done(input int budget);
    int n0 = n_done;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (n_done != n0) break;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset;
    RESET = 1; bus.start = 0; bus.cfg_num_pix = 0; bus.cfg_num_chunks = 0; bus.cfg_k_len = 0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    vec_cnt++;
    if (all_outs !== 56'd0) begin err_cnt++; $display("FAIL reset_outputs: got %0h expected 0", all_outs); end
    @(posedge CLK); #1;
    RESET = 0;
  endtask

  task automatic test_single;
    act_duty = 100; ready_duty = 100; psum_lat = 1;
    clear_env(1, 1, 1); begin_tile(1, 1, 1); wait_done(200);
    begin
      int got [7] = '{n_done, n_clear, n_step, n_qen, n_out, out_err, bad_inv};
      int exv [7] = '{1, 1, 1, 1, 1, 0, 0};
      string nm [7] = '{"t1_done", "t1_clear", "t1_step", "t1_qen", "t1_out", "t1_outdata", "t1_invariant"};
      for (int i = 0; i < 7; i++) begin
        vec_cnt++;
        if (got[i] !== exv[i]) begin err_cnt++; $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exv[i]); end
      end
    end
    vec_cnt++;
    if (done_cyc - commit_cyc > 8 || done_cyc <= commit_cyc) begin
      err_cnt++; $display("FAIL t1_latency: got %0d cycles expected 1..8", done_cyc - commit_cyc);
    end
  endtask

  task automatic test_multi_chunk;
    act_duty = 100; ready_duty = 100; psum_lat = 2;
    clear_env(4, 3, 64); begin_tile(4, 3, 64); wait_done(3000);
    begin
      int got [12] = '{n_done, n_wls, n_clear, n_write, n_read, n_load, n_qen, n_out, n_step,
                       out_err, seq_err, bad_inv};
      int exv [12] = '{1, 3, 4, 8, 8, 8, 4, 4, 768, 0, 0, 0};
      string nm [12] = '{"t2_done", "t2_wload", "t2_clear", "t2_write", "t2_read", "t2_load", "t2_qen",
                         "t2_out", "t2_steps", "t2_outdata", "t2_pixorder", "t2_invariant"};
      for (int i = 0; i < 12; i++) begin
        vec_cnt++;
        if (got[i] !== exv[i]) begin err_cnt++; $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exv[i]); end
      end
    end
  endtask

  task automatic test_random_stalls;
    act_duty = 30; ready_duty = 40; psum_lat = 3;
    clear_env(5, 3, 8); begin_tile(5, 3, 8); wait_done(5000);
    begin
      int got [5] = '{n_done, n_step, n_out, out_err, bad_inv};
      int exv [5] = '{1, 120, 5, 0, 0};
      string nm [5] = '{"t3_done", "t3_steps", "t3_out", "t3_outdata", "t3_stall_stable"};
      for (int i = 0; i < 5; i++) begin
        vec_cnt++;
        if (got[i] !== exv[i]) begin err_cnt++; $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exv[i]); end
      end
    end
  endtask

  task automatic test_clamp_and_zero;
    act_duty = 100; ready_duty = 100; psum_lat = 1;
    clear_env(200, 1, 1); begin_tile(200, 1, 1); wait_done(4000);
    begin
      int got [4] = '{n_done, n_out, n_clear, out_err};
      int exv [4] = '{1, 128, 128, 0};
      string nm [4] = '{"t4_done", "t4_clamped_out", "t4_clamped_clear", "t4_outdata"};
      for (int i = 0; i < 4; i++) begin
        vec_cnt++;
        if (got[i] !== exv[i]) begin err_cnt++; $display("FAIL %s: got %0d expected %0d", nm[i], got[i], exv[i]); end
      end
    end
    clear_env(1, 1, 1);
    @(posedge CLK); #1;
    bus.cfg_num_pix = 8'd3; bus.cfg_num_chunks = 8'd2; bus.cfg_k_len = 7'd0; bus.start = 1;
    @(posedge CLK); #1;
    bus.start = 0;
    @(negedge CLK);
    vec_cnt++;
    if (bus.done !== 1'b1 || flags !== 11'd0) begin
      err_cnt++; $display("FAIL t4_zero_done: got done=%0b flags=%0h expected done=1 flags=0", bus.done, flags);
    end
    @(negedge CLK);
    vec_cnt++;
    if (bus.done !== 1'b0 || flags !== 11'd0) begin
      err_cnt++; $display("FAIL t4_zero_after: got done=%0b flags=%0h expected done=0 flags=0", bus.done, flags);
    end
  endtask

  task automatic test_busy_start_and_abort;
    act_duty = 100; ready_duty = 100; psum_lat = 1;
    clear_env(2, 2, 4); begin_tile(2, 2, 4);
    repeat (6) @(posedge CLK);
    #1; bus.cfg_num_pix = 8'd9; bus.cfg_num_chunks = 8'd9; bus.cfg_k_len = 7'd9; bus.start = 1;
    @(posedge CLK); #1; bus.start = 0;
    wait_done(2000);
    vec_cnt++;
    if (n_done !== 1 || n_out !== 2 || n_wls !== 2 || out_err !== 0) begin
      err_cnt++; $display("FAIL t5_busy_start: got done=%0d out=%0d wload=%0d err=%0d expected 1 2 2 0",
                          n_done, n_out, n_wls, out_err);
    end
    clear_env(3, 2, 4); begin_tile(3, 2, 4);
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      if (env_chunk == 1 && bus.act_req) break;
    end
    vec_cnt++;
    if (env_chunk !== 1 || bus.act_req !== 1'b1) begin
      err_cnt++; $display("FAIL t5_reach_step: got chunk=%0d act_req=%0b expected 1 1", env_chunk, bus.act_req);
    end
    @(posedge CLK); #1; RESET = 1;
    @(posedge CLK);
    @(negedge CLK);
    vec_cnt++;
    if (all_outs !== 56'd0) begin err_cnt++; $display("FAIL t5_abort_outputs: got %0h expected 0", all_outs); end
    @(posedge CLK); #1; RESET = 0;
    repeat (20) @(negedge CLK);
    vec_cnt++;
    if (n_done !== 0) begin err_cnt++; $display("FAIL t5_abort_nodone: got %0d expected 0", n_done); end
    clear_env(3, 2, 4); begin_tile(3, 2, 4); wait_done(2000);
    vec_cnt++;
    if (n_done !== 1 || n_out !== 3 || out_err !== 0 || bad_inv !== 0) begin
      err_cnt++; $display("FAIL t5_fresh_tile: got done=%0d out=%0d err=%0d inv=%0d expected 1 3 0 0",
                          n_done, n_out, out_err, bad_inv);
    end
  endtask

  task automatic test_psum_latency;
    act_duty = 100; ready_duty = 100;
    for (int l = 1; l <= 4; l += 3) begin
      psum_lat = l;
      clear_env(2, 2, 2); begin_tile(2, 2, 2); wait_done(1000);
      vec_cnt++;
      if (n_done !== 1 || n_load !== 2 || n_read !== 2 || bad_inv !== 0 || out_err !== 0) begin
        err_cnt++; $display("FAIL t6_lat%0d: got done=%0d load=%0d read=%0d inv=%0d err=%0d expected 1 2 2 0 0",
                            l, n_done, n_load, n_read, bad_inv, out_err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi_chunk();
    test_random_stalls();
    test_clamp_and_zero();
    test_busy_start_and_abort();
    test_psum_latency();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
